// File: rtl/spi_pwm_config_ctrl.sv
// SPI mode-0 target that commits one PWM configuration register per 16-bit write frame.
// Optional build macro SPI_READBACK_EN: read frames shift the addressed register out on cipo.
module spi_pwm_config_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       frame_done
);
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

    localparam logic [6:0] MAX_ADDR_L = 7'(MAX_ADDR);

    logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
    logic                   sclk_prev_q, ncs_prev_q;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_rise, ncs_rise, ncs_fall;

    state_e      state_q;
    logic [4:0]  count_q;
    logic [15:0] shift_q;
    logic [15:0] shift_d;
    logic        frame_done_q;
    logic [7:0]  out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // The ncs chain resets low: releasing reset mid-frame then shows no falling edge, so decoding
    // waits for the next genuine frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            ncs_prev_q  <= ncs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;
    assign ncs_fall  = ~ncs_s & ncs_prev_q;
    assign shift_d   = {shift_q[14:0], copi_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            shift_q      <= '0;
            frame_done_q <= 1'b0;
            out_lo_q     <= '0;
            out_hi_q     <= '0;
            pwm_lo_q     <= '0;
            pwm_hi_q     <= '0;
            duty_q       <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ncs_fall) begin
                        count_q <= '0;
                        shift_q <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A chip-select release outranks an sclk edge seen in the same cycle.
                    if (ncs_rise) begin
                        state_q <= (count_q == 5'd16) ? COMMIT : IDLE;
                    end else if (sclk_rise && count_q != 5'd16) begin
                        shift_q <= shift_d;
                        count_q <= count_q + 5'd1;
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                    if (shift_q[15] && shift_q[14:8] <= MAX_ADDR_L) begin
                        frame_done_q <= 1'b1;
                        case (shift_q[14:8])
                            7'd0:    out_lo_q <= shift_q[7:0];
                            7'd1:    out_hi_q <= shift_q[7:0];
                            7'd2:    pwm_lo_q <= shift_q[7:0];
                            7'd3:    pwm_hi_q <= shift_q[7:0];
                            7'd4:    duty_q   <= shift_q[7:0];
                            default: ;
                        endcase
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign en_reg_out_7_0  = out_lo_q;
    assign en_reg_out_15_8 = out_hi_q;
    assign en_reg_pwm_7_0  = pwm_lo_q;
    assign en_reg_pwm_15_8 = pwm_hi_q;
    assign pwm_duty_cycle  = duty_q;
    assign frame_done      = frame_done_q;

`ifdef SPI_READBACK_EN
    logic       sclk_fall;
    logic [7:0] rd_data;
    logic [7:0] tx_q;
    logic       cipo_q;

    assign sclk_fall = ~sclk_s & sclk_prev_q;

    // Decode from the header as it will stand once the 8th bit lands; write frames load zeros.
    always_comb begin
        rd_data = 8'h00;
        if (!shift_d[7] && shift_d[6:0] <= MAX_ADDR_L) begin
            case (shift_d[6:0])
                7'd0:    rd_data = out_lo_q;
                7'd1:    rd_data = out_hi_q;
                7'd2:    rd_data = pwm_lo_q;
                7'd3:    rd_data = pwm_hi_q;
                7'd4:    rd_data = duty_q;
                default: rd_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q   <= '0;
            cipo_q <= 1'b0;
        end else if (state_q != SHIFT || ncs_s) begin
            tx_q   <= '0;
            cipo_q <= 1'b0;
        end else if (sclk_rise && !ncs_rise && count_q == 5'd7) begin
            tx_q <= rd_data;
        end else if (sclk_fall) begin
            cipo_q <= tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b0};
        end
    end

    assign cipo = cipo_q;
`else
    assign cipo = 1'b0;
`endif

endmodule
